// File: rtl/dht11_read_scheduler.sv
// DHT11 read sequencer: periodic or forced reads, per-read timeout, retry backoff, sticky fault.
// Define DHT11_SCHED_MINMAX_EN to track the running min/max of good temperatures.
module dht11_read_scheduler #(
  parameter int POLL_PERIOD = 250000000,
  parameter int TIMEOUT     = 1250000,
  parameter int RETRY_GAP   = 125000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic                             force_read_i,
  output logic                             rd_start_o,
  input  logic                             rd_busy_i,
  input  logic                             rd_done_i,
  input  logic                             rd_valid_i,
  input  logic [15:0]                      rd_humidity_i,
  input  logic [15:0]                      rd_temperature_i,
  output logic [15:0]                      humidity_o,
  output logic [15:0]                      temperature_o,
  output logic                             data_fresh_o,
  output logic                             sensor_fault_o,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt_o,
  output logic [15:0]                      temp_min_o,
  output logic [15:0]                      temp_max_o,
  output logic [2:0]                       state_o
);

  localparam int RW      = $clog2(MAX_RETRY + 1);
  localparam int TMR_MAX = (POLL_PERIOD > TIMEOUT) ?
                           ((POLL_PERIOD > RETRY_GAP) ? POLL_PERIOD : RETRY_GAP) :
                           ((TIMEOUT > RETRY_GAP) ? TIMEOUT : RETRY_GAP);
  localparam int TW      = $clog2(TMR_MAX + 1);

  localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(RETRY_GAP - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_CHECK   = 3'd3,
    S_BACKOFF = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            lat_valid_q, lat_valid_d;
  logic [15:0]     lat_hum_q, lat_hum_d;
  logic [15:0]     lat_temp_q, lat_temp_d;
  logic            rd_start_q, rd_start_d;
  logic [15:0]     hum_q, hum_d;
  logic [15:0]     temp_q, temp_d;
  logic            fresh_q, fresh_d;
  logic            fault_q, fault_d;
  logic [RW-1:0]   retry_q, retry_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      lat_valid_q <= 1'b0;
      lat_hum_q   <= '0;
      lat_temp_q  <= '0;
      rd_start_q  <= 1'b0;
      hum_q       <= '0;
      temp_q      <= '0;
      fresh_q     <= 1'b0;
      fault_q     <= 1'b0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      lat_valid_q <= lat_valid_d;
      lat_hum_q   <= lat_hum_d;
      lat_temp_q  <= lat_temp_d;
      rd_start_q  <= rd_start_d;
      hum_q       <= hum_d;
      temp_q      <= temp_d;
      fresh_q     <= fresh_d;
      fault_q     <= fault_d;
      retry_q     <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (enable_i && (force_read_i || tmr_q == POLL_LAST)) state_d = S_START;
      S_START:   if (!rd_busy_i) state_d = S_WAIT;
      S_WAIT:    if (rd_done_i || tmr_q == TO_LAST) state_d = S_CHECK;
      S_CHECK:   state_d = (!lat_valid_q && retry_q != RETRY_LAST) ? S_BACKOFF : S_IDLE;
      S_BACKOFF: if (tmr_q == GAP_LAST) state_d = S_START;
      default:   state_d = S_IDLE;
    endcase
  end

  // One timer serves poll period, read timeout and backoff; it restarts on every state change.
  always_comb begin
    tmr_d = (state_d != state_q) ? '0 : tmr_q + 1'b1;
    if (state_q == S_IDLE && !enable_i) tmr_d = '0;

    rd_start_d = (state_q == S_START) && !rd_busy_i;

    lat_valid_d = lat_valid_q;
    lat_hum_d   = lat_hum_q;
    lat_temp_d  = lat_temp_q;
    if (state_q == S_WAIT) begin
      if (rd_done_i) begin
        lat_valid_d = rd_valid_i;
        lat_hum_d   = rd_humidity_i;
        lat_temp_d  = rd_temperature_i;
      end else if (tmr_q == TO_LAST) begin
        lat_valid_d = 1'b0;
      end
    end

    hum_d   = hum_q;
    temp_d  = temp_q;
    fresh_d = 1'b0;
    fault_d = fault_q;
    retry_d = retry_q;
    if (state_q == S_CHECK) begin
      if (lat_valid_q) begin
        hum_d   = lat_hum_q;
        temp_d  = lat_temp_q;
        fresh_d = 1'b1;
        fault_d = 1'b0;
        retry_d = '0;
      end else if (retry_q != RETRY_LAST) begin
        retry_d = retry_q + 1'b1;
      end else begin
        fault_d = 1'b1;
        retry_d = '0;
      end
    end
  end

`ifdef DHT11_SCHED_MINMAX_EN
  logic [15:0] tmin_q, tmax_q;
  logic        seen_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmin_q <= '0;
      tmax_q <= '0;
      seen_q <= 1'b0;
    end else if (state_q == S_CHECK && lat_valid_q) begin
      if (!seen_q || lat_temp_q < tmin_q) tmin_q <= lat_temp_q;
      if (!seen_q || lat_temp_q > tmax_q) tmax_q <= lat_temp_q;
      seen_q <= 1'b1;
    end
  end
  assign temp_min_o = tmin_q;
  assign temp_max_o = tmax_q;
`else
  assign temp_min_o = '0;
  assign temp_max_o = '0;
`endif

  assign rd_start_o     = rd_start_q;
  assign humidity_o     = hum_q;
  assign temperature_o  = temp_q;
  assign data_fresh_o   = fresh_q;
  assign sensor_fault_o = fault_q;
  assign retry_cnt_o    = retry_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Directed bench for dht11_read_scheduler with POLL_PERIOD=100, TIMEOUT=20, RETRY_GAP=10, MAX_RETRY=2.
module tb_dht11_read_scheduler;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        force_read_i = 1'b0;
  logic        rd_busy_i = 1'b0;
  logic        rd_done_i = 1'b0;
  logic        rd_valid_i = 1'b0;
  logic [15:0] rd_humidity_i = '0;
  logic [15:0] rd_temperature_i = '0;
  logic        rd_start_o;
  logic [15:0] humidity_o;
  logic [15:0] temperature_o;
  logic        data_fresh_o;
  logic        sensor_fault_o;
  logic [1:0]  retry_cnt_o;
  logic [15:0] temp_min_o;
  logic [15:0] temp_max_o;
  logic [2:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;

  dht11_read_scheduler #(
    .POLL_PERIOD(100), .TIMEOUT(20), .RETRY_GAP(10), .MAX_RETRY(2)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .force_read_i(force_read_i),
    .rd_start_o(rd_start_o), .rd_busy_i(rd_busy_i), .rd_done_i(rd_done_i),
    .rd_valid_i(rd_valid_i), .rd_humidity_i(rd_humidity_i),
    .rd_temperature_i(rd_temperature_i), .humidity_o(humidity_o),
    .temperature_o(temperature_o), .data_fresh_o(data_fresh_o),
    .sensor_fault_o(sensor_fault_o), .retry_cnt_o(retry_cnt_o),
    .temp_min_o(temp_min_o), .temp_max_o(temp_max_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mm(input string tag, input logic [15:0] mn, input logic [15:0] mx);
`ifdef DHT11_SCHED_MINMAX_EN
    chk({tag, "_min"}, 32'(temp_min_o), 32'(mn));
    chk({tag, "_max"}, 32'(temp_max_o), 32'(mx));
`else
    chk({tag, "_min"}, 32'(temp_min_o), 32'(mn & 16'h0));
    chk({tag, "_max"}, 32'(temp_max_o), 32'(mx & 16'h0));
`endif
  endtask

  // Returns cycles until rd_start is seen, or -1 if the bound expires.
  task automatic wait_start(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (rd_start_o) begin
        n = i;
        break;
      end
    end
  endtask

  // Engine answers in the current cycle; returns two cycles later when results are visible.
  task automatic engine_reply(input logic v, input logic [15:0] h, input logic [15:0] t);
    rd_done_i = 1'b1; rd_valid_i = v; rd_humidity_i = h; rd_temperature_i = t;
    step();
    rd_done_i = 1'b0; rd_valid_i = 1'b0; rd_humidity_i = '0; rd_temperature_i = '0;
    chk("check_state", 32'(state_o), 32'd3);
    step();
  endtask

  int n;
  int pulses;

  initial begin
    repeat (3) step();
    rst_i = 1'b0;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_start", 32'(rd_start_o), 32'd0);
    chk("rst_hum", 32'(humidity_o), 32'd0);
    chk("rst_temp", 32'(temperature_o), 32'd0);
    chk("rst_fresh", 32'(data_fresh_o), 32'd0);
    chk("rst_fault", 32'(sensor_fault_o), 32'd0);
    chk("rst_retry", 32'(retry_cnt_o), 32'd0);
    chk_mm("rst", 16'h0, 16'h0);

    // Forced read: rd_start two cycles later, good data published two cycles after rd_done
    enable_i = 1'b1; force_read_i = 1'b1;
    step(); force_read_i = 1'b0;
    chk("force_state1", 32'(state_o), 32'd1);
    chk("force_nostart", 32'(rd_start_o), 32'd0);
    step();
    chk("force_start", 32'(rd_start_o), 32'd1);
    chk("force_wait", 32'(state_o), 32'd2);
    step();
    chk("start_pulse1", 32'(rd_start_o), 32'd0);
    engine_reply(1'b1, 16'h3A00, 16'h1900);
    chk("g1_fresh", 32'(data_fresh_o), 32'd1);
    chk("g1_hum", 32'(humidity_o), 32'h3A00);
    chk("g1_temp", 32'(temperature_o), 32'h1900);
    chk("g1_idle", 32'(state_o), 32'd0);
    chk_mm("g1", 16'h1900, 16'h1900);
    step();
    chk("g1_fresh_off", 32'(data_fresh_o), 32'd0);
    chk("g1_hum_hold", 32'(humidity_o), 32'h3A00);

    // Periodic poll: IDLE counts 100 cycles then START
    wait_start(150, n);
    chk("poll_lat", 32'(n), 32'd100);

    // force_read during WAIT_DONE is dropped
    force_read_i = 1'b1;
    step(); force_read_i = 1'b0;
    chk("wd_force_state", 32'(state_o), 32'd2);
    chk("wd_force_nostart", 32'(rd_start_o), 32'd0);
    step();
    chk("wd_force_nostart2", 32'(rd_start_o), 32'd0);
    engine_reply(1'b1, 16'h3B00, 16'h1400);
    chk("g2_temp", 32'(temperature_o), 32'h1400);
    chk_mm("g2", 16'h1400, 16'h1900);

    // Two checksum failures then success
    force_read_i = 1'b1;
    step(); force_read_i = 1'b0;
    wait_start(5, n);
    chk("f1_lat", 32'(n), 32'd1);
    engine_reply(1'b0, 16'hDEAD, 16'hBEEF);
    chk("f1_retry", 32'(retry_cnt_o), 32'd1);
    chk("f1_state", 32'(state_o), 32'd4);
    chk("f1_hum_hold", 32'(humidity_o), 32'h3B00);
    chk("f1_fresh", 32'(data_fresh_o), 32'd0);
    wait_start(30, n);
    chk("bo1_lat", 32'(n), 32'd11);
    engine_reply(1'b0, 16'hDEAD, 16'hBEEF);
    chk("f2_retry", 32'(retry_cnt_o), 32'd2);
    chk("f2_fault", 32'(sensor_fault_o), 32'd0);
    wait_start(30, n);
    chk("bo2_lat", 32'(n), 32'd11);
    engine_reply(1'b1, 16'h3C00, 16'h1E00);
    chk("g3_fresh", 32'(data_fresh_o), 32'd1);
    chk("g3_retry", 32'(retry_cnt_o), 32'd0);
    chk("g3_fault", 32'(sensor_fault_o), 32'd0);
    chk("g3_hum", 32'(humidity_o), 32'h3C00);
    chk_mm("g3", 16'h1400, 16'h1E00);

    // Busy engine holds START; rd_start one cycle after busy drops
    rd_busy_i = 1'b1; force_read_i = 1'b1;
    step(); force_read_i = 1'b0;
    chk("busy_state", 32'(state_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("busy_hold", 32'(state_o), 32'd1);
      chk("busy_nostart", 32'(rd_start_o), 32'd0);
    end
    rd_busy_i = 1'b0;
    step();
    chk("busy_start", 32'(rd_start_o), 32'd1);

    // Engine silent: three timeouts lead to sensor_fault
    repeat (19) step();
    chk("to_wait19", 32'(state_o), 32'd2);
    step();
    chk("to_check20", 32'(state_o), 32'd3);
    step();
    chk("to1_retry", 32'(retry_cnt_o), 32'd1);
    chk("to1_state", 32'(state_o), 32'd4);
    wait_start(30, n);
    chk("to_bo1_lat", 32'(n), 32'd11);
    repeat (21) step();
    chk("to2_retry", 32'(retry_cnt_o), 32'd2);
    wait_start(30, n);
    chk("to_bo2_lat", 32'(n), 32'd11);
    repeat (21) step();
    chk("to3_fault", 32'(sensor_fault_o), 32'd1);
    chk("to3_retry", 32'(retry_cnt_o), 32'd0);
    chk("to3_state", 32'(state_o), 32'd0);
    chk("to3_hum_hold", 32'(humidity_o), 32'h3C00);
    chk("to3_temp_hold", 32'(temperature_o), 32'h1E00);

    // Good read clears the fault
    force_read_i = 1'b1;
    step(); force_read_i = 1'b0;
    wait_start(5, n);
    chk("g4_lat", 32'(n), 32'd1);
    engine_reply(1'b1, 16'h3A00, 16'h1900);
    chk("g4_fault", 32'(sensor_fault_o), 32'd0);
    chk("g4_fresh", 32'(data_fresh_o), 32'd1);
    chk_mm("g4", 16'h1400, 16'h1E00);

    // enable=0: no reads at all, force_read ignored
    enable_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      force_read_i = (i == 10);
      step();
      if (rd_start_o) pulses++;
    end
    force_read_i = 1'b0;
    chk("dis_pulses", 32'(pulses), 32'd0);
    chk("dis_state", 32'(state_o), 32'd0);

    // Reset in WAIT_DONE aborts and clears outputs
    enable_i = 1'b1; force_read_i = 1'b1;
    step(); force_read_i = 1'b0;
    wait_start(5, n);
    chk("r_lat", 32'(n), 32'd1);
    step();
    chk("r_wait", 32'(state_o), 32'd2);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("r_state", 32'(state_o), 32'd0);
    chk("r_hum", 32'(humidity_o), 32'd0);
    chk("r_temp", 32'(temperature_o), 32'd0);
    chk("r_retry", 32'(retry_cnt_o), 32'd0);
    chk("r_fault", 32'(sensor_fault_o), 32'd0);
    chk_mm("r", 16'h0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
